// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - op codes, FSM states and stack addresses for mem_sequencer
// MEMSEQ_READ16_EN decides whether op 001 is legal.
package mem_seq_pkg;

  localparam logic [2:0] OP_READ8  = 3'b000;
  localparam logic [2:0] OP_READ16 = 3'b001;
  localparam logic [2:0] OP_WRITE8 = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  localparam logic [15:0] STACK_HI = 16'hFFFE;
  localparam logic [15:0] STACK_LO = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE, MAR, RDH, INC, RDL, MDR, WR, CALLS, RETS, CAP, DONE
  } state_e;

  function automatic logic op_legal(input logic [2:0] o);
    case (o)
      OP_READ8, OP_WRITE8, OP_CALL, OP_RET: op_legal = 1'b1;
`ifdef MEMSEQ_READ16_EN
      OP_READ16: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - expands CPU memory ops into SAP-2 memory strobes and bus cycles
// READ16 (op 001) exists only when MEMSEQ_READ16_EN is defined.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              mar_loadh,
  output logic              mar_loadl,
  output logic              mdr_load,
  output logic              ram_load,
  output logic              ram_enh,
  output logic              ram_enl,
  output logic              call,
  output logic              ret
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, eff_op;
  logic [ADDR_W-1:0] addr_q, eff_addr;
  logic [DATA_W-1:0] wdata_q, eff_wdata;
  logic [DATA_W-1:0] rdata_q, rdata_d, bus_q, bus_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, drive_q, drive_d;
  logic loadh_q, loadh_d, loadl_q, loadl_d, mdrld_q, mdrld_d, ramld_q, ramld_d;
  logic enh_q, enh_d, enl_q, enl_d, call_q, call_d, ret_q, ret_d;

  // Outputs are decoded from the next state so they are registered yet aligned with state_q.
  always_comb begin
    state_d   = state_q;
    eff_op    = op_q;
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    case (state_q)
      IDLE: if (req) begin
        eff_op    = op;
        eff_addr  = addr;
        eff_wdata = wdata;
        if (!op_legal(op))       state_d = DONE;
        else if (op == OP_CALL)  state_d = CALLS;
        else if (op == OP_RET)   state_d = RETS;
        else                     state_d = MAR;
      end
      MAR: begin
        if (op_q == OP_WRITE8) state_d = MDR;
`ifdef MEMSEQ_READ16_EN
        else if (op_q == OP_READ16) state_d = RDH;
`endif
        else state_d = RDL;
      end
`ifdef MEMSEQ_READ16_EN
      RDH:   state_d = INC;
      INC:   state_d = RDL;
`endif
      RDL:   state_d = CAP;
      MDR:   state_d = WR;
      WR:    state_d = DONE;
      CALLS: state_d = DONE;
      RETS:  state_d = CAP;
      CAP:   state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdata_d = rdata_q;
    if (state_q == CAP)
      rdata_d = (op_q == OP_READ8) ? {{(DATA_W-8){1'b0}}, mem_out[7:0]} : mem_out;

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    err_d   = done_d && !op_legal(eff_op);
    bus_d   = '0;
    drive_d = 1'b0;
    loadh_d = 1'b0;
    loadl_d = 1'b0;
    mdrld_d = 1'b0;
    ramld_d = 1'b0;
    enh_d   = 1'b0;
    enl_d   = 1'b0;
    call_d  = 1'b0;
    ret_d   = 1'b0;
    case (state_d)
      MAR: begin
        bus_d   = DATA_W'(eff_addr);
        drive_d = 1'b1;
        loadh_d = 1'b1;
        loadl_d = 1'b1;
      end
`ifdef MEMSEQ_READ16_EN
      RDH: enh_d = 1'b1;
      INC: begin
        bus_d   = DATA_W'(eff_addr + ADDR_W'(1));
        drive_d = 1'b1;
        loadl_d = 1'b1;
        loadh_d = (eff_addr[7:0] == 8'hFF);
      end
`endif
      RDL: enl_d = 1'b1;
      MDR: begin
        bus_d   = {{(DATA_W-8){1'b0}}, eff_wdata[7:0]};
        drive_d = 1'b1;
        mdrld_d = 1'b1;
      end
      WR:  ramld_d = 1'b1;
      CALLS: begin
        bus_d   = eff_wdata;
        drive_d = 1'b1;
        call_d  = 1'b1;
      end
      RETS: ret_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bus_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drive_q <= 1'b0;
      loadh_q <= 1'b0;
      loadl_q <= 1'b0;
      mdrld_q <= 1'b0;
      ramld_q <= 1'b0;
      enh_q   <= 1'b0;
      enl_q   <= 1'b0;
      call_q  <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= eff_op;
      addr_q  <= eff_addr;
      wdata_q <= eff_wdata;
      rdata_q <= rdata_d;
      bus_q   <= bus_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      drive_q <= drive_d;
      loadh_q <= loadh_d;
      loadl_q <= loadl_d;
      mdrld_q <= mdrld_d;
      ramld_q <= ramld_d;
      enh_q   <= enh_d;
      enl_q   <= enl_d;
      call_q  <= call_d;
      ret_q   <= ret_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_out   = bus_q;
  assign bus_drive = drive_q;
  assign mar_loadh = loadh_q;
  assign mar_loadl = loadl_q;
  assign mdr_load  = mdrld_q;
  assign ram_load  = ramld_q;
  assign ram_enh   = enh_q;
  assign ram_enl   = enl_q;
  assign call      = call_q;
  assign ret       = ret_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - directed bench for mem_sequencer with a behavioural SAP-2 memory
// READ16 vectors are exercised when MEMSEQ_READ16_EN is defined, otherwise op 001 must be illegal.
module tb_mem_sequencer;
  import mem_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] addr = 16'h0, wdata = 16'h0;
  logic        busy, done, err, bus_drive;
  logic [15:0] rdata, bus_out, mem_out;
  logic        mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret;

  int checks = 0;
  int errors = 0;
  int lat;
  int n_loadh = 0;
  int n_ramld = 0;
  int snap;

  always #5 clk = ~clk;

  mem_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .mem_out(mem_out),
    .bus_out(bus_out), .bus_drive(bus_drive),
    .mar_loadh(mar_loadh), .mar_loadl(mar_loadl), .mdr_load(mdr_load),
    .ram_load(ram_load), .ram_enh(ram_enh), .ram_enl(ram_enl),
    .call(call), .ret(ret)
  );

  // Behavioural memory: MAR/MDR registers and a 64K byte array, plus a bench-side preload port.
  logic [7:0]  ram [0:65535];
  logic [15:0] mar = 16'h0, mdr = 16'h0;
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [7:0]  pl_data = 8'h0;
  wire  [15:0] bus = bus_drive ? bus_out : 16'h0;
  wire  [7:0]  strobes = {mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret};

  assign mem_out = mdr;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    if (mar_loadh) mar[15:8] <= bus[15:8];
    if (mar_loadl) mar[7:0] <= bus[7:0];
    if (mdr_load) mdr <= bus;
    if (ram_enh) mdr[15:8] <= ram[mar];
    if (ram_enl) mdr[7:0] <= ram[mar];
    if (ram_load) ram[mar] <= mdr[7:0];
    if (call) begin
      ram[STACK_HI] <= bus[15:8];
      ram[STACK_LO] <= bus[7:0];
    end
    if (ret) mdr <= {ram[STACK_HI], ram[STACK_LO]};
    if (mar_loadh) n_loadh <= n_loadh + 1;
    if (ram_load) n_ramld <= n_ramld + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issues one op, scrambles the inputs after acceptance, and returns the latency
  // (0 on timeout) while parked at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] w,
                        output int l);
    @(negedge clk);
    req = 1'b1;
    op = o;
    addr = a;
    wdata = w;
    @(negedge clk);
    req = 1'b0;
    op = 3'b111;
    addr = 16'hDEAD;
    wdata = 16'hBEAD;
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        l = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus", {bus_drive, bus_out}, 0);
    chk("rst_strobes", strobes, 0);

    poke(16'h1234, 8'hA5);
    poke(16'h12FF, 8'hBE);
    poke(16'h1300, 8'hEF);
    rst = 1'b0;

    run_op(OP_READ8, 16'h1234, 16'h0, lat);
    chk("rd8_lat", lat, 4);
    chk("rd8_rdata", rdata, 16'h00A5);
    chk("rd8_err", err, 0);
    chk("rd8_done_strobes", strobes, 0);

    snap = n_ramld;
    run_op(OP_WRITE8, 16'h4000, 16'h775A, lat);
    chk("wr8_lat", lat, 4);
    chk("wr8_rdata_hold", rdata, 16'h00A5);
    chk("wr8_ram_load_cnt", n_ramld - snap, 1);
    run_op(OP_READ8, 16'h4000, 16'h0, lat);
    chk("wr8_readback", rdata, 16'h005A);

    run_op(OP_CALL, 16'h0, 16'h0203, lat);
    chk("call_lat", lat, 2);
    chk("call_hi", ram[STACK_HI], 8'h02);
    chk("call_lo", ram[STACK_LO], 8'h03);
    run_op(OP_RET, 16'h0, 16'h0, lat);
    chk("ret_lat", lat, 3);
    chk("ret_rdata", rdata, 16'h0203);
    chk("ret_err", err, 0);

    run_op(3'b111, 16'h1234, 16'h0, lat);
    chk("ill_lat", lat, 1);
    chk("ill_err", err, 1);
    chk("ill_rdata_hold", rdata, 16'h0203);

`ifdef MEMSEQ_READ16_EN
    snap = n_loadh;
    run_op(OP_READ16, 16'h12FF, 16'h0, lat);
    chk("rd16_lat", lat, 6);
    chk("rd16_rdata", rdata, 16'hBEEF);
    chk("rd16_loadh_cnt", n_loadh - snap, 2);
    snap = n_loadh;
    run_op(OP_READ16, 16'h1234, 16'h0, lat);
    chk("rd16_nocarry_loadh_cnt", n_loadh - snap, 1);
    poke(16'hFFFF, 8'h11);
    poke(16'h0000, 8'h22);
    run_op(OP_READ16, 16'hFFFF, 16'h0, lat);
    chk("rd16_wrap", rdata, 16'h1122);
`else
    run_op(OP_READ16, 16'h12FF, 16'h0, lat);
    chk("rd16_off_lat", lat, 1);
    chk("rd16_off_err", err, 1);
`endif

    // req held high across done is re-accepted in the following IDLE cycle.
    @(negedge clk);
    req = 1'b1;
    op = 3'b111;
    @(negedge clk);
    chk("hold_done1", done, 1);
    @(negedge clk);
    chk("hold_idle", {busy, done}, 2'b00);
    @(negedge clk);
    chk("hold_done2", {done, err}, 2'b11);
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_released", {busy, done}, 2'b00);

    // Reset in the middle of a read, in the first enable cycle.
    @(negedge clk);
    req = 1'b1;
`ifdef MEMSEQ_READ16_EN
    op = OP_READ16;
`else
    op = OP_READ8;
`endif
    addr = 16'h1234;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
`ifdef MEMSEQ_READ16_EN
    chk("midrst_pre_enh", ram_enh, 1);
`else
    chk("midrst_pre_enl", ram_enl, 1);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_strobes", {strobes, bus_drive}, 0);
    chk("midrst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_quiet", {busy, done, strobes}, 0);

    run_op(OP_READ8, 16'h1234, 16'h0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_rdata", rdata, 16'h00A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
